// File: rtl/trace_uart_tx_if.sv
// Retirement-trace bus: the core drives retired PCs and the clear strobe in,
// and the transmitter reports the serial line and its status flags back.
interface trace_uart_tx_if;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        ovf_clr;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_cnt;

  modport master (
    output retire_valid, retire_pc, ovf_clr,
    input  tx, busy, overflow, drop_cnt
  );

  modport slave (
    input  retire_valid, retire_pc, ovf_clr,
    output tx, busy, overflow, drop_cnt
  );
endinterface

// File: rtl/trace_uart_tx.sv
// Retirement-trace UART transmitter. Buffers retired PCs in a small FIFO and
// sends each one as a 5-byte 8N1 frame: SYNC_BYTE followed by the PC MSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle high, waiting for a buffered PC
// S_START | start bit (0) of the current byte
// S_DATA  | 8 data bits, LSB first, shifted out of sh_q
// S_STOP  | stop bit (1); picks next byte, next frame, or idle
module trace_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  trace_uart_tx_if.slave    bus
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full;
  logic        push, pop, drop;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  sh_q, sh_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        bit_done;
  logic [7:0]  next_byte;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A full FIFO still accepts a PC when a slot frees up on the same edge.
  assign push = bus.retire_valid && (!fifo_full || pop);
  assign drop = bus.retire_valid && !push;

  assign bit_done = (timer_q == 16'd0);

  // Select the PC byte that follows the one just sent (MSB first).
  always_comb begin
    next_byte = pc_q[7:0];
    case (byte_idx_q)
      3'd0:    next_byte = pc_q[31:24];
      3'd1:    next_byte = pc_q[23:16];
      3'd2:    next_byte = pc_q[15:8];
      default: next_byte = pc_q[7:0];
    endcase
  end

  // FIFO storage; entries need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.retire_pc;
  end

  // FSM next-state, bit timing and pop decision.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    pc_d       = pc_q;
    sh_d       = sh_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          pc_d       = mem_q[rd_ptr_q[AW-1:0]];
          sh_d       = SYNC_BYTE;
          byte_idx_d = 3'd0;
          timer_d    = BIT_LOAD;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          timer_d   = BIT_LOAD;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          timer_d   = BIT_LOAD;
          sh_d      = {1'b0, sh_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (byte_idx_q < 3'd4) begin
            byte_idx_d = byte_idx_q + 3'd1;
            sh_d       = next_byte;
            timer_d    = BIT_LOAD;
            state_d    = S_START;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop        = 1'b1;
            pc_d       = mem_q[rd_ptr_q[AW-1:0]];
            sh_d       = SYNC_BYTE;
            byte_idx_d = 3'd0;
            timer_d    = BIT_LOAD;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer and drop-flag updates; a drop outranks a simultaneous clear.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.ovf_clr)                 drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  // State registers; reset abandons any frame and flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      pc_q       <= 32'd0;
      sh_q       <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      pc_q       <= pc_d;
      sh_q       <= sh_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Line level decoded from state so reset forces idle-high immediately.
  always_comb begin
    bus.tx = 1'b1;
    case (state_q)
      S_START: bus.tx = 1'b0;
      S_DATA:  bus.tx = sh_q[0];
      default: bus.tx = 1'b1;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE) || !fifo_empty;
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench for trace_uart_tx at CLKS_PER_BIT=4: latency, frame decode,
// back-to-back frames, overflow, full-plus-pop, saturation and reset.
module tb_trace_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   e0c;
  int   guard;

  logic       smp   [0:1999];
  logic [7:0] exp_b [0:49];
  logic [7:0] got;

  trace_uart_tx_if bus ();

  trace_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_frame(input int f, input logic [31:0] pc);
    exp_b[5*f]   = 8'hA5;
    exp_b[5*f+1] = pc[31:24];
    exp_b[5*f+2] = pc[23:16];
    exp_b[5*f+3] = pc[15:8];
    exp_b[5*f+4] = pc[7:0];
  endtask

  // Called just after the edge that begins the first start bit; samples every
  // cycle and decodes bytes at bit centres (each bit spans 4 samples).
  task automatic record_check(input int nbytes, input string tag);
    for (int c = 0; c < nbytes * 40; c++) begin
      smp[c] = bus.tx;
      if (c == nbytes * 40 - 1) chk({tag, "_busy_last"}, bus.busy, 1);
      tick();
    end
    for (int i = 0; i < nbytes; i++) begin
      chk($sformatf("%s_start%0d", tag, i), smp[40*i+2], 0);
      for (int j = 0; j < 8; j++) got[j] = smp[40*i + 4*(j+1) + 2];
      chk($sformatf("%s_byte%0d", tag, i), got, exp_b[i]);
      chk($sformatf("%s_stop%0d", tag, i), smp[40*i+38], 1);
    end
  endtask

  initial begin
    bus.retire_valid = 1'b0;
    bus.retire_pc    = 32'd0;
    bus.ovf_clr      = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    rst = 1'b0;
    tick();

    // Single PC: capture at E0, start bit after E1, 200-cycle frame
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h8000_0004;
    tick();
    bus.retire_valid = 1'b0; bus.retire_pc = 32'hDEAD_BEEF;
    chk("single_busy_e0", bus.busy, 1);
    chk("single_tx_e0", bus.tx, 1);
    tick();
    chk("single_tx_e1", bus.tx, 0);
    set_frame(0, 32'h8000_0004);
    record_check(5, "single");
    chk("single_busy_end", bus.busy, 0);
    chk("single_tx_end", bus.tx, 1);
    tick(); tick();

    // Back-to-back frames, contiguous, in order
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h0000_0010;
    tick();
    bus.retire_pc = 32'h0000_0014;
    tick();
    bus.retire_valid = 1'b0;
    set_frame(0, 32'h0000_0010);
    set_frame(1, 32'h0000_0014);
    record_check(10, "b2b");
    chk("b2b_busy_end", bus.busy, 0);
    tick();

    // Overflow: 12 pulses, 9 accepted, 3 dropped
    e0c = cyc + 1;
    for (int k = 0; k < 12; k++) begin
      bus.retire_valid = 1'b1; bus.retire_pc = 32'h100 + 32'(4*k);
      tick();
    end
    bus.retire_valid = 1'b0;
    chk("ovf_drop", bus.drop_cnt, 3);
    chk("ovf_flag", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr_drop", bus.drop_cnt, 0);
    chk("ovf_clr_flag", bus.overflow, 0);
    while (cyc < e0c + 1601) tick();
    set_frame(0, 32'h0000_0120);
    record_check(5, "ovf_last");
    chk("ovf_busy_end", bus.busy, 0);
    tick();

    // Full plus pop: retire on the pop edge E201 is accepted
    e0c = cyc + 1;
    for (int k = 0; k < 9; k++) begin
      bus.retire_valid = 1'b1; bus.retire_pc = 32'h200 + 32'(4*k);
      tick();
    end
    bus.retire_valid = 1'b0;
    while (cyc < e0c + 200) tick();
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h0000_02FC;
    tick();
    bus.retire_valid = 1'b0;
    chk("fullpop_drop", bus.drop_cnt, 0);
    chk("fullpop_ovf", bus.overflow, 0);
    while (cyc < e0c + 1801) tick();
    set_frame(0, 32'h0000_02FC);
    record_check(5, "fullpop_last");
    chk("fullpop_busy_end", bus.busy, 0);
    tick();

    // Saturation: continuous retires for 66000 cycles
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h0000_4000;
    for (int k = 0; k < 66000; k++) tick();
    chk("sat_drop", bus.drop_cnt, 32'h0000_FFFF);
    chk("sat_ovf", bus.overflow, 1);
    // Clear racing a drop: drop wins
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0; bus.retire_valid = 1'b0;
    chk("race_drop", bus.drop_cnt, 1);
    chk("race_ovf", bus.overflow, 1);

    // Reset mid-frame while tx is low
    guard = 0;
    while (bus.tx !== 1'b0 && guard < 200) begin tick(); guard++; end
    chk("rstmid_tx_low", bus.tx, 0);
    #2 rst = 1'b1;
    #1 chk("rstmid_tx_async", bus.tx, 1);
    tick(); tick(); tick();
    chk("rstmid_tx", bus.tx, 1);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_ovf", bus.overflow, 0);
    chk("rstmid_drop", bus.drop_cnt, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("rstmid_flushed_busy", bus.busy, 0);
    chk("rstmid_flushed_tx", bus.tx, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
